// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter for the shared memory port.
// One outstanding transaction, fixed latency, per-requester burst lock.
module mem_arbiter_rr #(
   parameter int N_REQ   = 3,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ-1:0]            req_lock,
   input  logic [N_REQ-1:0]            req_we,
   input  logic [N_REQ*ADDR_W-1:0]     req_addr,
   input  logic [N_REQ*DATA_W-1:0]     req_wdata,
   input  logic [N_REQ*DATA_W/8-1:0]   req_be,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   input  logic                        mem_ready,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic [DATA_W/8-1:0]         mem_be,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy,
   output logic [$clog2(N_REQ)-1:0]    grant_id
);

   localparam int GW = $clog2(N_REQ);
   localparam int BW = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t          state;
   logic [GW-1:0]   ptr;
   logic            lock_valid;
   logic [GW-1:0]   lock_owner;
   logic [GW-1:0]   owner;
   logic            is_wr;
   logic [3:0]      cnt;
   logic [GW-1:0]   g;
   logic            found;
   logic            active;

   function automatic logic [GW-1:0] wrap_add(
      input logic [GW-1:0] base,
      input int            k
   );
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return GW'(s);
   endfunction

   // Locked owner wins; otherwise scan upward from the last grant.
   always_comb begin
      g     = '0;
      found = 1'b0;
      if (lock_valid && req_valid[lock_owner]) begin
         g     = lock_owner;
         found = 1'b1;
      end else begin
         for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req_valid[wrap_add(ptr, k)]) begin
               g     = wrap_add(ptr, k);
               found = 1'b1;
            end
         end
      end
   end

   assign active = reset && (state == IDLE) && found;

   always_comb begin
      req_ready = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (active) begin
         req_ready[g] = mem_ready;
         mem_en       = mem_ready;
         mem_we       = req_we[g];
         mem_addr     = req_addr[int'(g)*ADDR_W +: ADDR_W];
         mem_wdata    = req_wdata[int'(g)*DATA_W +: DATA_W];
         mem_be       = req_be[int'(g)*BW +: BW];
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (state == RESP) rsp_valid[owner] = 1'b1;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ptr        <= GW'(N_REQ - 1);
         lock_valid <= 1'b0;
         lock_owner <= '0;
         owner      <= '0;
         grant_id   <= '0;
         is_wr      <= 1'b0;
         cnt        <= '0;
         rsp_rdata  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (mem_en) begin
                  owner      <= g;
                  grant_id   <= g;
                  ptr        <= g;
                  lock_valid <= req_lock[g];
                  lock_owner <= g;
                  is_wr      <= req_we[g];
                  cnt        <= 4'(MEM_LAT - 1);
                  state      <= WAIT;
               end else if (lock_valid && !req_valid[lock_owner]) begin
                  lock_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  rsp_rdata <= is_wr ? '0 : mem_rdata;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: scoreboard bench for mem_arbiter_rr.
// Two instances: MEM_LAT=1 (main) and MEM_LAT=4 (latency check).
module tb_mem_arbiter_rr;

   logic clock;
   logic reset;

   logic [2:0]   req_valid, req_ready, req_lock, req_we, rsp_valid;
   logic [95:0]  req_addr, req_wdata;
   logic [11:0]  req_be;
   logic [31:0]  rsp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic         mem_ready, mem_en, mem_we, busy;
   logic [3:0]   mem_be;
   logic [1:0]   grant_id;

   logic [2:0]   req_valid4, req_ready4, rsp_valid4;
   logic [95:0]  req_addr4;
   logic [31:0]  rsp_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
   logic         mem_en4, mem_we4, busy4;
   logic [3:0]   mem_be4;
   logic [1:0]   grant_id4;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int          id;
      logic [31:0] data;
   } exp_t;
   exp_t sbq[$];

   mem_arbiter_rr #(.N_REQ(3), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
   );

   mem_arbiter_rr #(.N_REQ(3), .ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u_dut4 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid4), .req_ready(req_ready4), .req_lock(3'b000),
      .req_we(3'b000), .req_addr(req_addr4), .req_wdata(96'h0),
      .req_be(12'hFFF), .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4),
      .mem_ready(1'b1), .mem_en(mem_en4), .mem_we(mem_we4),
      .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_be(mem_be4),
      .mem_rdata(mem_rdata4), .busy(busy4), .grant_id(grant_id4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : ~a;
   endfunction

   // Memory models: data is valid only in the cycle MEM_LAT after accept.
   logic [3:0]  mcnt, mcnt4;
   logic [31:0] maddr, maddr4;
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mcnt <= 0; maddr <= 0; mcnt4 <= 0; maddr4 <= 0;
      end else begin
         if (mem_en) begin mcnt <= 4'd1; maddr <= mem_addr; end
         else if (mcnt != 0) mcnt <= mcnt - 4'd1;
         if (mem_en4) begin mcnt4 <= 4'd4; maddr4 <= mem_addr4; end
         else if (mcnt4 != 0) mcnt4 <= mcnt4 - 4'd1;
      end
   end
   assign mem_rdata  = (mcnt == 4'd1)  ? mem_fn(maddr)  : 32'h0BAD0BAD;
   assign mem_rdata4 = (mcnt4 == 4'd1) ? mem_fn(maddr4) : 32'h0BAD0BAD;

   // Response monitor: every rsp_valid pulse must match the queue head.
   always @(negedge clock) begin
      exp_t e;
      if (reset && rsp_valid != 3'b000) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected got=%b exp=none", rsp_valid);
         end else begin
            e = sbq.pop_front();
            if (rsp_valid !== (3'b001 << e.id) || rsp_rdata !== e.data) begin
               failures++;
               $display("FAIL rsp_match got=%b/%h exp=%b/%h",
                        rsp_valid, rsp_rdata, 3'b001 << e.id, e.data);
            end
         end
      end
   end

   task automatic set_req(input int i, input bit v, input bit we,
                          input bit lk, input logic [31:0] a,
                          input logic [31:0] d);
      req_valid[i] = v;
      req_we[i] = we;
      req_lock[i] = lk;
      req_addr[i*32 +: 32] = a;
      req_wdata[i*32 +: 32] = d;
      req_be[i*4 +: 4] = 4'hF;
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock); #1;
         if (sbq.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      set_req(0, 1, 0, 0, 32'h10, 0);
      set_req(1, 1, 0, 0, 32'h14, 0);
      set_req(2, 1, 0, 0, 32'h18, 0);
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (req_ready !== 3'b000 || mem_en !== 1'b0 || busy !== 1'b0 ||
          rsp_valid !== 3'b000) begin
         failures++;
         $display("FAIL reset_outs got=%b/%b/%b/%b exp=0", req_ready,
                  mem_en, busy, rsp_valid);
      end
      checks++;
      if (grant_id !== 2'd0 || rsp_rdata !== 32'h0 || mem_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_regs got=%h/%h/%h exp=0", grant_id,
                  rsp_rdata, mem_addr);
      end
      req_valid = 3'b010;
      set_req(1, 1, 0, 0, 32'h40, 0);
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 3'b010) begin
         failures++;
         $display("FAIL pre_abort_ready got=%b exp=010", req_ready);
      end
      @(posedge clock); #1;
      req_valid = 3'b000;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_abort_busy got=%b exp=1", busy);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0 || rsp_valid !== 3'b000 ||
          grant_id !== 2'd0 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL abort_outs got=%b/%b/%b/%h/%h exp=0", busy,
                  mem_en, rsp_valid, grant_id, rsp_rdata);
      end
      @(negedge clock);
      reset = 1'b1;
      repeat (4) @(negedge clock);
      set_req(0, 1, 0, 0, 32'h10, 0);
      set_req(1, 1, 0, 0, 32'h14, 0);
      set_req(2, 1, 0, 0, 32'h18, 0);
      #1;
      checks++;
      if (req_ready !== 3'b001 || mem_addr !== 32'h10) begin
         failures++;
         $display("FAIL first_grant got=%b/%h exp=001/00000010",
                  req_ready, mem_addr);
      end
      sbq.push_back('{0, mem_fn(32'h10)});
      @(posedge clock); #1;
      req_valid = 3'b000;
      checks++;
      if (grant_id !== 2'd0) begin
         failures++;
         $display("FAIL first_grant_id got=%0d exp=0", grant_id);
      end
      drain(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL reset_drain got=timeout exp=idle");
      end
   endtask

   task automatic test_single_read();
      bit ok;
      @(negedge clock);
      set_req(1, 1, 0, 0, 32'h100, 0);
      #1;
      checks++;
      if (req_ready !== 3'b010 || mem_en !== 1'b1 || mem_addr !== 32'h100 ||
          mem_we !== 1'b0) begin
         failures++;
         $display("FAIL single_issue got=%b/%b/%h/%b exp=010/1/100/0",
                  req_ready, mem_en, mem_addr, mem_we);
      end
      sbq.push_back('{1, 32'hDEADBEEF});
      @(negedge clock); #1;
      req_valid = 3'b000;
      checks++;
      if (mem_en !== 1'b0 || rsp_valid !== 3'b000 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_wait got=%b/%b/%b exp=0/000/1", mem_en,
                  rsp_valid, busy);
      end
      @(negedge clock); #1;
      checks++;
      if (rsp_valid !== 3'b010 || rsp_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_rsp got=%b/%h exp=010/deadbeef", rsp_valid,
                  rsp_rdata);
      end
      drain(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL single_drain got=timeout exp=idle");
      end
   endtask

   task automatic test_round_robin();
      int ord[6] = '{0, 1, 2, 0, 1, 2};
      int k = 0;
      int cyc = 0;
      int last = -1;
      bit ok;
      @(negedge clock);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      @(negedge clock);
      set_req(0, 1, 0, 0, 32'h20, 0);
      set_req(1, 1, 0, 0, 32'h24, 0);
      set_req(2, 1, 0, 0, 32'h28, 0);
      for (int i = 0; i < 6; i++)
         sbq.push_back('{ord[i], mem_fn(32'h20 + 32'(4 * ord[i]))});
      while (k < 6 && cyc < 60) begin
         #1;
         if ((req_ready & req_valid) != 3'b000) begin
            checks++;
            if (req_ready !== (3'b001 << ord[k])) begin
               failures++;
               $display("FAIL rr_order[%0d] got=%b exp=%b", k, req_ready,
                        3'b001 << ord[k]);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last !== 3) begin
                  failures++;
                  $display("FAIL rr_spacing[%0d] got=%0d exp=3", k,
                           cyc - last);
               end
            end
            last = cyc;
            @(posedge clock); #1;
            checks++;
            if (grant_id !== 2'(ord[k])) begin
               failures++;
               $display("FAIL rr_grant_id[%0d] got=%0d exp=%0d", k,
                        grant_id, ord[k]);
            end
            k++;
         end
         @(negedge clock);
         cyc++;
      end
      req_valid = 3'b000;
      checks++;
      if (k != 6) begin
         failures++;
         $display("FAIL rr_timeout got=%0d exp=6", k);
      end
      drain(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rr_drain got=timeout exp=idle");
      end
   endtask

   task automatic test_lock();
      int ord[4] = '{2, 2, 2, 0};
      int k = 0;
      int cyc = 0;
      bit ok;
      @(negedge clock);
      set_req(2, 1, 1, 1, 32'h200, 32'h12345678);
      for (int i = 0; i < 3; i++) sbq.push_back('{2, 32'h0});
      sbq.push_back('{0, mem_fn(32'h300)});
      while (k < 4 && cyc < 60) begin
         #1;
         if ((req_ready & req_valid) != 3'b000) begin
            checks++;
            if (req_ready !== (3'b001 << ord[k]) ||
                mem_we !== (ord[k] == 2)) begin
               failures++;
               $display("FAIL lock_order[%0d] got=%b/%b exp=%b/%b", k,
                        req_ready, mem_we, 3'b001 << ord[k], ord[k] == 2);
            end
            if (ord[k] == 2) begin
               checks++;
               if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h200) begin
                  failures++;
                  $display("FAIL lock_payload[%0d] got=%h/%h exp=12345678/200",
                           k, mem_wdata, mem_addr);
               end
            end
            @(posedge clock); #1;
            k++;
            if (k == 1) set_req(0, 1, 0, 0, 32'h300, 0);
            if (k == 3) req_valid[2] = 1'b0;
         end
         @(negedge clock);
         cyc++;
      end
      req_valid = 3'b000;
      checks++;
      if (k != 4) begin
         failures++;
         $display("FAIL lock_timeout got=%0d exp=4", k);
      end
      drain(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL lock_drain got=timeout exp=idle");
      end
   endtask

   task automatic test_mem_stall();
      bit ok;
      @(negedge clock);
      mem_ready = 1'b0;
      set_req(0, 1, 0, 0, 32'h400, 0);
      sbq.push_back('{0, mem_fn(32'h400)});
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (req_ready !== 3'b000 || mem_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall[%0d] got=%b/%b/%b exp=000/0/0", i,
                     req_ready, mem_en, busy);
         end
         @(negedge clock);
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 3'b001 || mem_en !== 1'b1 || mem_addr !== 32'h400) begin
         failures++;
         $display("FAIL stall_release got=%b/%b/%h exp=001/1/400",
                  req_ready, mem_en, mem_addr);
      end
      @(posedge clock); #1;
      req_valid = 3'b000;
      checks++;
      if (busy !== 1'b1 || grant_id !== 2'd0) begin
         failures++;
         $display("FAIL stall_accept got=%b/%0d exp=1/0", busy, grant_id);
      end
      drain(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL stall_drain got=timeout exp=idle");
      end
   endtask

   task automatic test_lat4();
      int bc = 0;
      @(negedge clock);
      req_valid4 = 3'b001;
      req_addr4[31:0] = 32'h44;
      #1;
      checks++;
      if (req_ready4 !== 3'b001 || mem_en4 !== 1'b1) begin
         failures++;
         $display("FAIL lat4_issue got=%b/%b exp=001/1", req_ready4, mem_en4);
      end
      @(posedge clock); #1;
      req_valid4 = 3'b000;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock); #1;
         if (busy4) bc++;
         checks++;
         if (i == 5) begin
            if (rsp_valid4 !== 3'b001 || rsp_rdata4 !== mem_fn(32'h44)) begin
               failures++;
               $display("FAIL lat4_rsp got=%b/%h exp=001/%h", rsp_valid4,
                        rsp_rdata4, mem_fn(32'h44));
            end
         end else if (rsp_valid4 !== 3'b000) begin
            failures++;
            $display("FAIL lat4_early[%0d] got=%b exp=000", i, rsp_valid4);
         end
      end
      checks++;
      if (bc != 5) begin
         failures++;
         $display("FAIL lat4_busy got=%0d exp=5", bc);
      end
   endtask

   initial begin
      reset = 1'b0;
      mem_ready = 1'b1;
      req_valid = '0; req_lock = '0; req_we = '0;
      req_addr = '0; req_wdata = '0; req_be = '0;
      req_valid4 = '0; req_addr4 = '0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock();
      test_mem_stall();
      test_lat4();
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Round-robin arbiter that shares the single memory port of the Wildcat SoC between N requesters: instruction fetch, data load/store, and the adaptive FPU operand/result port. It sits between the requesters and the on-chip memory/MMIO interconnect. It allows one outstanding transaction at a time and waits a fixed memory latency before returning a response. A per-requester lock keeps a burst on the same requester.

Parameters:
N_REQ, 3, number of requesters (port 0 = imem, 1 = dmem, 2 = fpu); legal range 2..8
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
MEM_LAT, 1, cycles from memory accept to mem_rdata valid; legal range 1..15

Ports:
clock  in  1  system clock; all logic rising-edge
reset  in  1  asynchronous, active-low reset (low = reset asserted)
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle
req_lock  in  N_REQ  hold grant for the next request from the same requester
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses slice i
req_wdata  in  N_REQ*DATA_W  packed write data
req_be  in  N_REQ*DATA_W/8  packed byte enables
rsp_valid  out  N_REQ  one-cycle response pulse to the owning requester
rsp_rdata  out  DATA_W  read data, shared by all requesters; 0 for writes
mem_ready  in  1  memory can accept a transaction this cycle
mem_en  out  1  memory transaction strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after accept
busy  out  1  high in WAIT and RESP
grant_id  out  clog2(N_REQ)  owner of the current or last transaction

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; ptr = N_REQ-1, so port 0 has top priority first; lock_valid = 0.
  - All outputs are 0.
  - An in-flight transaction is dropped and no rsp_valid is issued.
- States: IDLE, WAIT, RESP.
- IDLE, selection:
  - If lock_valid is set and req_valid[lock_owner] is high, grant lock_owner.
  - Otherwise grant the first requester with req_valid set, scanning ptr+1, ptr+2, ... with wrap modulo N_REQ.
- IDLE, handshake:
  - req_ready[g] = mem_ready (combinational). All other req_ready bits are 0.
  - mem_en, mem_we, mem_addr, mem_wdata and mem_be are driven combinationally from requester g's slices, with mem_en = req_valid[g] & mem_ready.
  - Accept = req_valid[g] & req_ready[g].
- On accept:
  - owner <= g; grant_id <= g; ptr <= g.
  - lock_valid <= req_lock[g]; lock_owner <= g.
  - is_wr <= req_we[g]; cnt <= MEM_LAT-1; state -> WAIT.
- If mem_ready is low or no requester is valid, nothing is accepted and ptr and lock state are unchanged.
- A lock is released when the locked owner has req_valid low in IDLE; lock_valid is cleared that cycle and round-robin arbitration applies.
- WAIT:
  - All req_ready are 0; mem_en is 0 and the other mem_* outputs are 0.
  - cnt decrements each cycle.
  - When cnt == 0, capture rsp_rdata <= is_wr ? 0 : mem_rdata and go to RESP.
- RESP:
  - rsp_valid[owner] = 1 for exactly one cycle, with rsp_rdata stable.
  - state -> IDLE. No accept happens in RESP.
- rsp_rdata holds its value until the next capture.
- Throughput: one transaction per MEM_LAT+2 cycles (accept, MEM_LAT-1 WAIT cycles, capture, RESP). Response latency is MEM_LAT+1 cycles after the accept edge.
- Requesters must hold req_valid and their payload until accepted. If a requester withdraws early, the arbiter re-evaluates every IDLE cycle and never grants on stale data.
- Simultaneous requests are resolved purely by ptr. No requester waits more than N_REQ-1 transactions unless a lock is held.
- An address is forwarded unchanged; decode and errors belong to the interconnect.

Test Plan:
- Reset, then hold reset low mid-WAIT -> all outputs 0 immediately; no rsp_valid after release; first grant with all three valid goes to port 0.
- Only dmem reads addr 0x100, mem_rdata = 0xDEADBEEF at MEM_LAT=1 -> mem_en for 1 cycle, rsp_valid[1] 2 cycles after accept, rsp_rdata = 0xDEADBEEF, rsp_valid[0] and rsp_valid[2] stay 0.
- All three requesters continuously valid -> grant order 0,1,2,0,1,2; each accept spaced 3 cycles apart; grant_id follows the same order.
- fpu write with req_lock = 1 for 3 back-to-back requests while imem is valid -> fpu granted 3 times in a row, then imem; write responses have rsp_rdata = 0.
- mem_ready low for 5 cycles with imem valid -> req_ready stays 0, ptr unchanged; accept on the first cycle mem_ready is high.
- MEM_LAT=4 build -> data captured 4 cycles after accept, rsp_valid at cycle 5; busy high for 5 cycles.
